// File: rtl/intr_ctrl.sv
// Interrupt front-end for the OTTER control FSM: synchronise, edge-detect and latch sources.
// Optional debounce stage enabled by defining INTR_DEBOUNCE_EN.
module intr_ctrl #(
   parameter  int NUM_SRC         = 4,
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int IDW             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               RST_N,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic [NUM_SRC-1:0] mask,
   input  logic               mie,
   input  logic               int_taken,
   output logic               INTR,
   output logic [IDW-1:0]     int_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] overrun
);

   if (NUM_SRC < 1 || NUM_SRC > 16 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("intr_ctrl: unsupported NUM_SRC/DEBOUNCE_CYCLES");
   end

   logic [NUM_SRC-1:0] s1, s2, q, q_prev;
   logic [NUM_SRC-1:0] rise, sv, set_vec, clr_vec;
   logic [IDW-1:0]     id_sel;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= src_in;
         s2 <= s1;
      end
   end

`ifdef INTR_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0]      cnt [NUM_SRC];
   logic [NUM_SRC-1:0] db;

   // State flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement with s2.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         db <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign q = db;
`else
   assign q = s2;
`endif

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) q_prev <= '0;
      else        q_prev <= q;
   end

   assign rise    = q & ~q_prev;
   assign set_vec = rise & mask;
   assign sv      = pending & mask;
   assign INTR    = mie & (|sv);

   // Lowest index wins.
   always_comb begin
      logic found;
      id_sel = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (sv[i] && !found) begin
            id_sel = IDW'(i);
            found  = 1'b1;
         end
      end
   end

   assign int_id = id_sel;

   always_comb begin
      clr_vec = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++)
         clr_vec[i] = int_taken & INTR & (id_sel == IDW'(i));
   end

   // A set in the clear cycle wins over the clear and does not count as an overrun.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= (pending & ~clr_vec) | set_vec;
         overrun <= (overrun & ~clr_vec) | (set_vec & pending & ~clr_vec);
      end
   end

endmodule
